// File: rtl/return_stack.sv
// Hardware return-address stack: circular register array with a wrapping top pointer and sticky error flags.
// Define RETURN_STACK_WRAP_EN to make a push on a full stack overwrite the oldest entry instead of being dropped.
module return_stack #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned Depth     = 8,
  parameter int unsigned PtrWidth  = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Push,
  input  logic                 Pop,
  input  logic                 Err_Rst,
  input  logic [DataWidth-1:0] DIn,
  output logic [DataWidth-1:0] DOut,
  output logic [PtrWidth:0]    Count,
  output logic                 Empty,
  output logic                 Full,
  output logic                 Overflow,
  output logic                 Underflow
);

  localparam int unsigned CntWidth = PtrWidth + 1;
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0]  top_q, top_d;
  logic [CntWidth-1:0]  count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 wr_en;
  logic [PtrWidth-1:0]  wr_idx;
  logic                 is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DepthCnt);

  // Next-state: replace, push, pop and error-flag updates; error events win over Err_Rst
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q & ~Err_Rst;
    unf_d   = unf_q & ~Err_Rst;
    wr_en   = 1'b0;
    wr_idx  = top_q + PtrWidth'(1);

    if (Push && Pop && !is_empty) begin
      wr_en  = 1'b1;
      wr_idx = top_q;
    end else if (Push) begin
      if (!is_full) begin
        wr_en   = 1'b1;
        top_d   = top_q + PtrWidth'(1);
        count_d = count_q + CntWidth'(1);
      end else begin
        ovf_d = 1'b1;
`ifdef RETURN_STACK_WRAP_EN
        wr_en = 1'b1;
        top_d = top_q + PtrWidth'(1);
`endif
      end
    end else if (Pop) begin
      if (!is_empty) begin
        top_d   = top_q - PtrWidth'(1);
        count_d = count_q - CntWidth'(1);
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; Count alone decides which entries are valid
  always_ff @(posedge Clk) begin
    if (wr_en && !Reset) begin
      mem_q[wr_idx] <= DIn;
    end
  end

  assign DOut      = is_empty ? '0 : mem_q[top_q];
  assign Count     = count_q;
  assign Empty     = is_empty;
  assign Full      = is_full;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed self-checking bench for return_stack at Depth=4, DataWidth=16.
// Full-stack expectations follow RETURN_STACK_WRAP_EN when it is defined.
module tb_return_stack;

  localparam int unsigned DW = 16;
  localparam int unsigned DP = 4;
  localparam int unsigned PW = 2;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Push = 1'b0;
  logic          Pop = 1'b0;
  logic          Err_Rst = 1'b0;
  logic [DW-1:0] DIn = '0;
  logic [DW-1:0] DOut;
  logic [PW:0]   Count;
  logic          Empty, Full, Overflow, Underflow;

  int pass_cnt = 0;
  int total_cnt = 0;

  return_stack #(.DataWidth(DW), .Depth(DP), .PtrWidth(PW)) dut (
    .Clk(Clk), .Reset(Reset), .Push(Push), .Pop(Pop), .Err_Rst(Err_Rst),
    .DIn(DIn), .DOut(DOut), .Count(Count), .Empty(Empty), .Full(Full),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 Clk = ~Clk;

  // One clock cycle with the given controls, then sample-safe point #1 after the edge
  task automatic cyc(input logic p, input logic po, input logic e, input logic r,
                     input logic [DW-1:0] d);
    Push = p; Pop = po; Err_Rst = e; Reset = r; DIn = d;
    @(posedge Clk); #1;
    Push = 1'b0; Pop = 1'b0; Err_Rst = 1'b0; Reset = 1'b0; DIn = '0;
  endtask

  task automatic test_reset;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h00AA);
    total_cnt++; if (Count !== 3'd0) $display("FAIL reset_count: got %0d exp 0", Count); else pass_cnt++;
    total_cnt++; if (Empty !== 1'b1) $display("FAIL reset_empty: got %b exp 1", Empty); else pass_cnt++;
    total_cnt++; if (Full !== 1'b0) $display("FAIL reset_full: got %b exp 0", Full); else pass_cnt++;
    total_cnt++; if (DOut !== 16'h0000) $display("FAIL reset_dout: got %h exp 0000", DOut); else pass_cnt++;
    total_cnt++; if ({Overflow, Underflow} !== 2'b00) $display("FAIL reset_flags: got %b exp 00", {Overflow, Underflow}); else pass_cnt++;
  endtask

  task automatic test_push_pop;
    logic [DW-1:0] exp_pop [3];
    exp_pop = '{16'h0020, 16'h0010, 16'h0000};
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010);
    total_cnt++; if (DOut !== 16'h0010) $display("FAIL push1_latency: got %h exp 0010", DOut); else pass_cnt++;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0020);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0030);
    total_cnt++; if (Count !== 3'd3) $display("FAIL push3_count: got %0d exp 3", Count); else pass_cnt++;
    total_cnt++; if (DOut !== 16'h0030) $display("FAIL push3_dout: got %h exp 0030", DOut); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
      total_cnt++; if (DOut !== exp_pop[i]) $display("FAIL pop%0d_dout: got %h exp %h", i, DOut, exp_pop[i]); else pass_cnt++;
    end
    total_cnt++; if (Empty !== 1'b1) $display("FAIL pops_empty: got %b exp 1", Empty); else pass_cnt++;
  endtask

  task automatic test_underflow;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    total_cnt++; if (Underflow !== 1'b1) $display("FAIL unf_set: got %b exp 1", Underflow); else pass_cnt++;
    total_cnt++; if (Count !== 3'd0) $display("FAIL unf_count: got %0d exp 0", Count); else pass_cnt++;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    total_cnt++; if (Underflow !== 1'b1) $display("FAIL unf_sticky: got %b exp 1", Underflow); else pass_cnt++;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    total_cnt++; if (Underflow !== 1'b0) $display("FAIL unf_clear: got %b exp 0", Underflow); else pass_cnt++;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    total_cnt++; if (Underflow !== 1'b1) $display("FAIL unf_set_wins: got %b exp 1", Underflow); else pass_cnt++;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    // Push+Pop on an empty stack is a plain push and must not flag underflow
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0077);
    total_cnt++; if (Count !== 3'd1) $display("FAIL pp_empty_count: got %0d exp 1", Count); else pass_cnt++;
    total_cnt++; if (DOut !== 16'h0077) $display("FAIL pp_empty_dout: got %h exp 0077", DOut); else pass_cnt++;
    total_cnt++; if (Underflow !== 1'b0) $display("FAIL pp_empty_unf: got %b exp 0", Underflow); else pass_cnt++;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_replace;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0020);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0099);
    total_cnt++; if (Count !== 3'd2) $display("FAIL replace_count: got %0d exp 2", Count); else pass_cnt++;
    total_cnt++; if (DOut !== 16'h0099) $display("FAIL replace_dout: got %h exp 0099", DOut); else pass_cnt++;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    total_cnt++; if (DOut !== 16'h0010) $display("FAIL replace_pop: got %h exp 0010", DOut); else pass_cnt++;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    total_cnt++; if (Empty !== 1'b1) $display("FAIL replace_empty: got %b exp 1", Empty); else pass_cnt++;
  endtask

  task automatic test_full;
    logic [DW-1:0] exp_pop [4];
    logic [DW-1:0] exp_top;
`ifdef RETURN_STACK_WRAP_EN
    exp_pop = '{16'h0005, 16'h0004, 16'h0003, 16'h0002};
    exp_top = 16'h0005;
`else
    exp_pop = '{16'h0004, 16'h0003, 16'h0002, 16'h0001};
    exp_top = 16'h0004;
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(i));
      if (i == 4) begin
        total_cnt++; if (Overflow !== 1'b0) $display("FAIL full_no_ovf_yet: got %b exp 0", Overflow); else pass_cnt++;
      end
    end
    total_cnt++; if (Count !== 3'd4) $display("FAIL full_count: got %0d exp 4", Count); else pass_cnt++;
    total_cnt++; if (Full !== 1'b1) $display("FAIL full_flag: got %b exp 1", Full); else pass_cnt++;
    total_cnt++; if (Overflow !== 1'b1) $display("FAIL full_ovf: got %b exp 1", Overflow); else pass_cnt++;
    total_cnt++; if (DOut !== exp_top) $display("FAIL full_dout: got %h exp %h", DOut, exp_top); else pass_cnt++;
    total_cnt++; if (dut.top_q !== 2'(exp_top)) $display("FAIL full_ptr: got %0d exp %0d", dut.top_q, 2'(exp_top)); else pass_cnt++;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    total_cnt++; if (Full !== 1'b0) $display("FAIL full_after_pop: got %b exp 0", Full); else pass_cnt++;
    total_cnt++; if (DOut !== exp_pop[1]) $display("FAIL full_pop0: got %h exp %h", DOut, exp_pop[1]); else pass_cnt++;
    for (int i = 2; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
      total_cnt++; if (DOut !== exp_pop[i]) $display("FAIL full_pop%0d: got %h exp %h", i, DOut, exp_pop[i]); else pass_cnt++;
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    total_cnt++; if (Empty !== 1'b1) $display("FAIL full_drained: got %b exp 1", Empty); else pass_cnt++;
    total_cnt++; if (Overflow !== 1'b1) $display("FAIL ovf_sticky: got %b exp 1", Overflow); else pass_cnt++;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    total_cnt++; if (Overflow !== 1'b0) $display("FAIL ovf_clear: got %b exp 0", Overflow); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(16'h0100 + i));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    total_cnt++; if (Count !== 3'd3) $display("FAIL mid_pre_count: got %0d exp 3", Count); else pass_cnt++;
    total_cnt++; if ({Overflow, Underflow} !== 2'b11) $display("FAIL mid_pre_flags: got %b exp 11", {Overflow, Underflow}); else pass_cnt++;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h0ABC);
    total_cnt++; if (Count !== 3'd0) $display("FAIL mid_count: got %0d exp 0", Count); else pass_cnt++;
    total_cnt++; if (Empty !== 1'b1) $display("FAIL mid_empty: got %b exp 1", Empty); else pass_cnt++;
    total_cnt++; if (DOut !== 16'h0000) $display("FAIL mid_dout: got %h exp 0000", DOut); else pass_cnt++;
    total_cnt++; if ({Overflow, Underflow} !== 2'b00) $display("FAIL mid_flags: got %b exp 00", {Overflow, Underflow}); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    // Alternating push/pop across the pointer wrap point
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'hA001);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'hA002);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'hA003);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'hA004);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'hA005);
    total_cnt++; if (Count !== 3'd4) $display("FAIL b2b_count: got %0d exp 4", Count); else pass_cnt++;
    total_cnt++; if (DOut !== 16'hA005) $display("FAIL b2b_top: got %h exp A005", DOut); else pass_cnt++;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    total_cnt++; if (DOut !== 16'hA001) $display("FAIL b2b_bottom: got %h exp A001", DOut); else pass_cnt++;
    total_cnt++; if (Overflow !== 1'b0) $display("FAIL b2b_ovf: got %b exp 0", Overflow); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_underflow();
    test_replace();
    test_full();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 SHALL have parameter DataWidth, default 16, meaning width of each stored return address.
REQ-002 SHALL have parameter Depth, default 8, meaning the number of entries; a power of two, at least 2.
REQ-003 SHALL have parameter PtrWidth, default 3, meaning log2(Depth).
REQ-004 SHALL have port Clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset  input  1  meaning the reset, which is synchronous and active-high.
REQ-006 SHALL have port Push  input  1  meaning write DIn as the new top this cycle.
REQ-007 SHALL have port Pop  input  1  meaning discard the top this cycle.
REQ-008 SHALL have port Err_Rst  input  1  meaning clear the sticky Overflow and Underflow flags.
REQ-009 SHALL have port DIn  input  DataWidth  meaning the address to push (the incremented PC).
REQ-010 SHALL have port DOut  output  DataWidth  meaning the current top of stack, feeding the PC source mux.
REQ-011 SHALL have port Count  output  PtrWidth+1  meaning the number of valid entries, 0..Depth.
REQ-012 SHALL have port Empty  output  1  meaning Count==0.
REQ-013 SHALL have port Full  output  1  meaning Count==Depth.
REQ-014 SHALL have port Overflow  output  1  meaning sticky push-when-full indicator.
REQ-015 SHALL have port Underflow  output  1  meaning sticky pop-when-empty indicator.

Function
REQ-016 SHALL store entries in a circular register array indexed by a PtrWidth-bit top pointer that wraps modulo Depth.
REQ-017 SHALL drive DOut combinationally from the entry at the top pointer when Count>0, and as all zeros when Count==0.
REQ-018 Push only, not full: SHALL store DIn at top+1 (mod Depth), advance the pointer, increment Count; DOut==DIn the next cycle.
REQ-019 Pop only, Count>0: SHALL retreat the pointer (mod Depth) and decrement Count; stored data is not cleared.
REQ-020 Push and Pop together, Count>0: SHALL overwrite the top entry with DIn, leaving pointer and Count unchanged (replace).
REQ-021 Push and Pop together, Count==0: SHALL behave as a push only; Underflow is not set.
REQ-022 Pop only, Count==0: SHALL leave state unchanged and set Underflow.
REQ-023 Push only, Count==Depth: SHALL set Overflow; full-case storage behaviour is per REQ-029/REQ-030.
REQ-024 Overflow and Underflow SHALL remain set until Reset or Err_Rst.
REQ-025 When Err_Rst coincides with a new error event, the flag SHALL be set (set wins).
REQ-026 Latency SHALL be one cycle: the effect of Push/Pop is visible on all outputs the cycle after the sampling edge.

Reset
REQ-027 On Clk edge with Reset high: Count=0, pointer=0, Overflow=0, Underflow=0, Empty=1, Full=0, DOut=0; Push/Pop ignored that cycle.
REQ-028 Reset asserted mid-sequence SHALL discard all entries; array contents need not be cleared.

Configuration
REQ-029 With macro RETURN_STACK_WRAP_EN defined, push when full SHALL overwrite the oldest entry, advance the pointer, and keep Count==Depth (circular, newest Depth entries retained).
REQ-030 Without RETURN_STACK_WRAP_EN, push when full SHALL be ignored (array, pointer and Count unchanged); only Overflow is set.

Verification (Depth=4, DataWidth=16)
REQ-031 Reset, then push 0x0010, 0x0020, 0x0030 -> Count=3, DOut=0x0030; then three pops -> DOut 0x0020, 0x0010, 0x0000, Empty=1.
REQ-032 Pop with Count=0 -> Underflow=1, Count=0; Err_Rst one cycle -> Underflow=0; Err_Rst together with another empty pop -> Underflow stays 1.
REQ-033 Count=2 top 0x0020, Push+Pop with DIn=0x0099 -> Count=2, DOut=0x0099; pop -> DOut=0x0010.
REQ-034 Push 0x1..0x5 without macro -> Count=4, Full=1, Overflow=1, DOut=0x4; four pops return 0x4,0x3,0x2,0x1.
REQ-035 Push 0x1..0x5 with RETURN_STACK_WRAP_EN -> Count=4, Overflow=1, DOut=0x5; four pops return 0x5,0x4,0x3,0x2, then Empty=1.
REQ-036 Count=3, Reset asserted together with Push -> next cycle Count=0, Empty=1, DOut=0, flags 0.
